// File: rtl/lcd_stream.sv
// HD44780 character-LCD streamer: buffers {rs, byte} entries in a small FIFO and
// plays them onto a 4- or 8-bit panel bus after running the power-on init sequence.
module lcd_stream #(
  parameter int BUS4     = 1,
  parameter int E_CYC    = 4,
  parameter int CMD_WAIT = 1000,
  parameter int CLR_WAIT = 40000,
  parameter int DEPTH    = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_byte,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_d,
  output logic       init_done,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [7:0]    E_LOAD   = 8'(E_CYC - 1);
  localparam logic [19:0]   CMD_LOAD = 20'(CMD_WAIT - 1);
  localparam logic [19:0]   CLR_LOAD = 20'(CLR_WAIT - 1);
  localparam logic [3:0]    INIT_END = (BUS4 != 0) ? 4'd8 : 4'd7;

  typedef enum logic [2:0] {INIT, IDLE, SETUP, STROBE, HOLD, WAIT} state_t;

  state_t        state;
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          push, pop;
  logic [8:0]    head, init_cur;
  logic [3:0]    step;
  logic [7:0]    e_cnt;
  logic [19:0]   wait_cnt;
  logic          half, cur_rs, cur_single;
  logic [7:0]    cur_byte;

  // Bus value for one transfer: nibble on [7:4] in 4-bit mode, whole byte otherwise.
  function automatic logic [7:0] bus_val(input logic [7:0] b, input logic lo);
    if (BUS4 != 0) return lo ? {b[3:0], 4'h0} : {b[7:4], 4'h0};
    return b;
  endfunction

  // Init table entries as {single_transfer, byte}.
  function automatic logic [8:0] init_item(input logic [3:0] s);
    if (s <= 4'd2) return {1'b1, 8'h30};
    if (BUS4 != 0) begin
      case (s)
        4'd3:    return {1'b1, 8'h20};
        4'd4:    return {1'b0, 8'h28};
        4'd5:    return {1'b0, 8'h0C};
        4'd6:    return {1'b0, 8'h01};
        default: return {1'b0, 8'h06};
      endcase
    end
    case (s)
      4'd3:    return {1'b0, 8'h38};
      4'd4:    return {1'b0, 8'h0C};
      4'd5:    return {1'b0, 8'h01};
      default: return {1'b0, 8'h06};
    endcase
  endfunction

  function automatic logic [19:0] wait_load(input logic rs, input logic [7:0] b,
                                            input logic single);
    if (single || (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03))) return CLR_LOAD;
    return CMD_LOAD;
  endfunction

  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (count != '0) && init_done;
  assign head     = mem[rd_ptr];
  assign init_cur = init_item(step);

  always_comb begin
    count_nxt = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {in_rs, in_byte};
  end

  // FIFO control; in_ready is registered from the next-cycle occupancy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      in_ready <= (count_nxt != FULL);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= INIT;
      step       <= '0;
      e_cnt      <= '0;
      wait_cnt   <= '0;
      half       <= 1'b0;
      cur_rs     <= 1'b0;
      cur_byte   <= '0;
      cur_single <= 1'b0;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_d      <= '0;
      init_done  <= 1'b0;
      busy       <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          {cur_single, cur_byte} <= init_cur;
          cur_rs <= 1'b0;
          half   <= 1'b0;
          lcd_rs <= 1'b0;
          lcd_d  <= bus_val(init_cur[7:0], 1'b0);
          step   <= step + 1'b1;
          busy   <= 1'b1;
          state  <= SETUP;
        end
        IDLE: begin
          if (pop) begin
            {cur_rs, cur_byte} <= head;
            cur_single <= 1'b0;
            half       <= 1'b0;
            lcd_rs     <= head[8];
            lcd_d      <= bus_val(head[7:0], 1'b0);
            busy       <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          lcd_e <= 1'b1;
          e_cnt <= E_LOAD;
          state <= STROBE;
        end
        STROBE: begin
          if (e_cnt == '0) begin
            lcd_e <= 1'b0;
            state <= HOLD;
          end else begin
            e_cnt <= e_cnt - 1'b1;
          end
        end
        HOLD: begin
          // Full bytes on a 4-bit bus go round again for the low nibble.
          if ((BUS4 != 0) && !cur_single && !half) begin
            half  <= 1'b1;
            lcd_d <= bus_val(cur_byte, 1'b1);
            state <= SETUP;
          end else begin
            wait_cnt <= wait_load(cur_rs, cur_byte, cur_single);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            if (init_done) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else if (step == INIT_END) begin
              init_done <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              state <= INIT;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_stream.sv
// Bench for lcd_stream: a 4-bit and an 8-bit instance share stimulus; accepted
// entries feed a per-instance transfer scoreboard checked by bus monitors.
module tb_lcd_stream;
  localparam int E_CYC = 2;
  localparam int CMD_W = 5;
  localparam int CLR_W = 9;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] in_valid;
  logic       in_rs;
  logic [7:0] in_byte;
  logic [1:0] in_ready, lcd_rs, lcd_e, init_done, busy;
  logic [7:0] lcd_d [2];

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic       intra;
    int         wt;
  } xfer_t;

  xfer_t exp_q [2][$];
  int    checks = 0;
  int    errors = 0;
  int    acc_cnt [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    lcd_stream #(.BUS4(k == 0 ? 1 : 0), .E_CYC(E_CYC), .CMD_WAIT(CMD_W),
                 .CLR_WAIT(CLR_W), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid[k]), .in_ready(in_ready[k]),
      .in_rs(in_rs), .in_byte(in_byte), .lcd_rs(lcd_rs[k]), .lcd_e(lcd_e[k]),
      .lcd_d(lcd_d[k]), .init_done(init_done[k]), .busy(busy[k]));
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int wait_for(input logic rs, input logic [7:0] b);
    return (!rs && b >= 8'h01 && b <= 8'h03) ? CLR_W : CMD_W;
  endfunction

  function automatic void push_xfer(input int k, input logic rs, input logic [7:0] d,
                                    input logic intra, input int wt);
    xfer_t x;
    x.rs = rs; x.d = d; x.intra = intra; x.wt = wt;
    exp_q[k].push_back(x);
  endfunction

  // Instance 0 is the 4-bit bus: high nibble then low nibble, both on [7:4].
  function automatic void model_byte(input int k, input logic rs, input logic [7:0] b);
    if (k == 0) begin
      push_xfer(k, rs, {b[7:4], 4'h0}, 1'b1, 0);
      push_xfer(k, rs, {b[3:0], 4'h0}, 1'b0, wait_for(rs, b));
    end else begin
      push_xfer(k, rs, b, 1'b0, wait_for(rs, b));
    end
  endfunction

  function automatic void model_init(input int k);
    exp_q[k].delete();
    for (int i = 0; i < 3; i++) push_xfer(k, 1'b0, 8'h30, 1'b0, CLR_W);
    if (k == 0) push_xfer(k, 1'b0, 8'h20, 1'b0, CLR_W);
    model_byte(k, 1'b0, (k == 0) ? 8'h28 : 8'h38);
    model_byte(k, 1'b0, 8'h0C);
    model_byte(k, 1'b0, 8'h01);
    model_byte(k, 1'b0, 8'h06);
  endfunction

  always @(posedge CLK) begin
    if (!RST) begin
      for (int k = 0; k < 2; k++) begin
        if (in_valid[k] && in_ready[k]) begin
          model_byte(k, in_rs, in_byte);
          acc_cnt[k]++;
        end
      end
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_mon
    logic       prev_e, prev_rs, gap_on;
    logic [7:0] prev_d;
    int         width, gap;
    xfer_t      cur;

    always @(negedge CLK) begin
      if (RST) begin
        prev_e = 1'b0; prev_rs = 1'b0; prev_d = 8'h00; gap_on = 1'b0; width = 0; gap = 0;
      end else begin
        if (lcd_e[k] && !prev_e) begin
          if (gap_on) chk($sformatf("gap_to_next%0d", k), gap, cur.intra ? 2 : cur.wt + 3);
          gap_on = 1'b0;
          if (exp_q[k].size() == 0) begin
            chk($sformatf("spurious_strobe%0d", k), 0, 1);
          end else begin
            cur = exp_q[k].pop_front();
            chk($sformatf("rs%0d", k), lcd_rs[k], cur.rs);
            chk($sformatf("data%0d", k), lcd_d[k], cur.d);
            chk($sformatf("setup_data%0d", k), prev_d, cur.d);
            chk($sformatf("setup_rs%0d", k), prev_rs, cur.rs);
          end
          width = 1;
        end else if (lcd_e[k]) begin
          width++;
        end else if (prev_e) begin
          chk($sformatf("e_width%0d", k), width, E_CYC);
          chk($sformatf("hold_data%0d", k), lcd_d[k], cur.d);
          gap = 1;
          gap_on = 1'b1;
        end else if (gap_on) begin
          if (busy[k]) gap++;
          else begin
            chk($sformatf("wait_to_idle%0d", k), gap, cur.intra ? -1 : cur.wt + 1);
            gap_on = 1'b0;
          end
        end
        prev_e = lcd_e[k]; prev_d = lcd_d[k]; prev_rs = lcd_rs[k];
      end
    end
  end

  // Caller is positioned at a falling edge; reset is raised immediately.
  task automatic do_reset();
    RST = 1'b1;
    in_valid = 2'b00;
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_e%0d", k), lcd_e[k], 0);
      chk($sformatf("rst_rs%0d", k), lcd_rs[k], 0);
      chk($sformatf("rst_d%0d", k), lcd_d[k], 0);
      chk($sformatf("rst_init_done%0d", k), init_done[k], 0);
      chk($sformatf("rst_busy%0d", k), busy[k], 1);
      chk($sformatf("rst_in_ready%0d", k), in_ready[k], 0);
    end
    @(negedge CLK);
    model_init(0);
    model_init(1);
    RST = 1'b0;
    @(negedge CLK);
    for (int k = 0; k < 2; k++) chk($sformatf("ready_after_rst%0d", k), in_ready[k], 1);
  endtask

  task automatic send(input logic rs, input logic [7:0] b);
    logic [1:0] acc;
    @(negedge CLK);
    in_rs = rs;
    in_byte = b;
    in_valid = 2'b11;
    for (int n = 0; n < 5000 && in_valid != 2'b00; n++) begin
      @(posedge CLK);
      acc = in_valid & in_ready;
      @(negedge CLK);
      in_valid = in_valid & ~acc;
    end
    if (in_valid != 2'b00) begin
      chk("send_timeout", int'(in_valid), 0);
      in_valid = 2'b00;
    end
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int n = 0; n < 20000 && !done; n++) begin
      @(negedge CLK);
      done = (busy == 2'b00) && (init_done == 2'b11) &&
             (exp_q[0].size() == 0) && (exp_q[1].size() == 0);
    end
    chk({name, "_idle"}, int'(done), 1);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_init_done%0d", name, k), init_done[k], 1);
      chk($sformatf("%s_pending%0d", name, k), exp_q[k].size(), 0);
    end
  endtask

  initial begin
    in_valid = 2'b00;
    in_rs = 1'b0;
    in_byte = 8'h00;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    @(negedge CLK);
    do_reset();

    // Overfill the FIFO while the panel is still initialising.
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_rs = 1'b1;
      in_byte = 8'h50 + 8'(i);
      in_valid = 2'b11;
      @(negedge CLK);
    end
    in_valid = 2'b00;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("full_ready%0d", k), in_ready[k], 0);
      chk($sformatf("accepted%0d", k), acc_cnt[k], DEPTH);
      chk($sformatf("still_init%0d", k), init_done[k], 0);
    end
    wait_idle("init_fill");

    send(1'b1, 8'h41);
    send(1'b0, 8'h80);
    wait_idle("directed");

    for (int i = 0; i < 30; i++) begin
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    send(1'b0, 8'h01);
    send(1'b0, 8'h03);
    wait_idle("random");

    for (int i = 0; i < 3; i++) send(1'b1, 8'h61 + 8'(i));
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 2000 && !seen; n++) begin
        @(negedge CLK);
        seen = lcd_e[0] && lcd_rs[0];
      end
      chk("data_strobe_seen", int'(seen), 1);
    end
    do_reset();
    wait_idle("restart");
    repeat (40) @(negedge CLK);
    for (int k = 0; k < 2; k++) chk($sformatf("quiet_after_restart%0d", k), busy[k], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_stream.md
LCD_STREAM -- requirements
Module: lcd_stream

Interface
REQ-001 Parameter BUS4, default 1, meaning 1 = 4-bit HD44780 bus and 0 = 8-bit bus.
REQ-002 Parameter E_CYC, default 4, meaning number of clocks lcd_e is held high per strobe (range 1..255).
REQ-003 Parameter CMD_WAIT, default 1000, meaning idle clocks after each completed byte (range 1..2^20-1).
REQ-004 Parameter CLR_WAIT, default 40000, meaning idle clocks after a clear/home command and after each init wake nibble (range 1..2^20-1).
REQ-005 Parameter DEPTH, default 8, meaning input FIFO entries (power of two, 2..64).
REQ-006 CLK  input  1  system clock; all logic on its rising edge.
REQ-007 RST  input  1  synchronous reset, active-high.
REQ-008 in_valid  input  1  producer offers an entry.
REQ-009 in_ready  output  1  FIFO not full; an entry is accepted when in_valid && in_ready.
REQ-010 in_rs  input  1  0 = command, 1 = character data.
REQ-011 in_byte  input  8  command or character code.
REQ-012 lcd_rs  output  1  register select to the panel.
REQ-013 lcd_e  output  1  enable strobe to the panel.
REQ-014 lcd_d  output  8  panel data; when BUS4=1, nibble on [7:4] and [3:0] driven 0.
REQ-015 init_done  output  1  panel initialisation sequence complete.
REQ-016 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 FIFO: DEPTH entries of {rs, byte}; an accepted entry becomes visible to the FSM on the next cycle; push while full is ignored; pop occurs only on the IDLE->SETUP transition.
REQ-018 FSM states: INIT, IDLE, SETUP, STROBE, HOLD, WAIT.
REQ-019 Transfer timing: SETUP is 1 clock with lcd_e=0 and lcd_rs/lcd_d driven; STROBE is E_CYC clocks with lcd_e=1; HOLD is 1 clock with lcd_e=0 and the data unchanged.
REQ-020 BUS4=1: each byte is sent as two transfers, high nibble first, SETUP->STROBE->HOLD each; lcd_rs stays constant across both.
REQ-021 After the final HOLD of a byte, the FSM enters WAIT for CLR_WAIT clocks if rs=0 and byte is 0x01, 0x02 or 0x03, otherwise for CMD_WAIT clocks; it then returns to IDLE.
REQ-022 The WAIT counter is 20 bits, loads N-1 on entry, and exits when it reaches 0; wait of exactly N clocks.
REQ-023 IDLE->SETUP occurs when the FIFO is non-empty and init_done=1; otherwise the FSM stays in IDLE.
REQ-024 INIT sequence starts automatically after reset, rs=0 throughout.
REQ-025 INIT wake phase: three wake transfers of 0x3 (on lcd_d[7:4] if BUS4=1, 0x30 if BUS4=0), each a single transfer followed by CLR_WAIT.
REQ-026 INIT with BUS4=1 then sends a single-transfer nibble 0x2 followed by CLR_WAIT.
REQ-027 INIT then sends full bytes per the normal rules: 0x28 (BUS4=1) or 0x38 (BUS4=0), then 0x0C, then 0x01, then 0x06.
REQ-028 init_done rises on the cycle IDLE is first entered after INIT and stays high until reset.
REQ-029 FIFO accepts entries during INIT; they are held until init_done.
REQ-030 Simultaneous push and pop on a full FIFO: pop completes; push is refused because in_ready=0 that cycle.
REQ-031 FIFO pointers wrap modulo DEPTH; count is exact across wrap.

Reset
REQ-032 RST is synchronous, active-high, with priority over all other logic.
REQ-033 Reset values: lcd_e=0, lcd_rs=0, lcd_d=0, init_done=0, busy=1, in_ready=0, FIFO empty, FSM=INIT at step 0, counters 0.
REQ-034 in_ready rises on the first cycle after RST deasserts.
REQ-035 Reset asserted mid-strobe drops lcd_e to 0 on the next edge, discards FIFO contents, and restarts INIT in full.

Verification
REQ-036 BUS4=1, E_CYC=2, small waits, reset released -> lcd_d[7:4] shows 3,3,3,2 then the nibble pairs of 0x28,0x0C,0x01,0x06; the wait after 0x01 equals CLR_WAIT; init_done rises.
REQ-037 After init, push rs=1 byte 0x41 -> lcd_rs=1, lcd_d[7:4]=4 then 1, each with lcd_e high for exactly 2 clocks and 1 clock of setup and hold; busy falls CMD_WAIT clocks after the last HOLD.
REQ-038 BUS4=0, push rs=0 byte 0x80 -> single strobe with lcd_d=0x80, followed by a CMD_WAIT wait.
REQ-039 Push DEPTH+2 entries back-to-back during INIT -> in_ready low after DEPTH accepts; exactly the first DEPTH bytes appear on the bus, in order, after init.
REQ-040 Assert RST during STROBE of a data byte -> next cycle lcd_e=0 and the FIFO is empty; the wake sequence then restarts.
